if_fetch: RTL and testbench

- Instruction-fetch stage: the producer side of the decode stage's pc/inst input, feeding the IF/ID register.
- Keeps the PC and issues word fetches to the memory controller over a req/valid handshake.
- Delivers one instruction per handshake to IF/ID. Holds it while stall_ctrl stalls and redirects on EX jump/branch.
- Raises stall_if_o to stall_ctrl while a fetch is outstanding.

---
 rtl/if_fetch_pkg.sv | 10 +
 rtl/if_fetch_if.sv | 12 +
 rtl/if_fetch.sv | 90 +++++++++
 tb/tb_if_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, FSM encodings and reset defaults for the fetch stage
package if_fetch_pkg;
  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int IF_STATE_LEN = 2;
  localparam logic [IF_STATE_LEN-1:0] IF_IDLE = 2'd0;
  localparam logic [IF_STATE_LEN-1:0] IF_BUSY = 2'd1;
  localparam logic [IF_STATE_LEN-1:0] IF_HOLD = 2'd2;
  localparam logic [ADDR_LEN-1:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: word-fetch req/valid handshake between the fetch stage and mem_ctrl
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic mem_valid_i;
  logic [INST_W-1:0] mem_data_i;
  modport master (output mem_req_o, mem_addr_o, input mem_valid_i, mem_data_i);
  modport slave (input mem_req_o, mem_addr_o, output mem_valid_i, mem_data_i);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: PC register, fetch FSM and one-entry hold buffer feeding IF/ID
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_LEN,
  parameter int INST_W = INST_LEN,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  input  logic jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  if_fetch_if.master mem,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic inst_valid_o,
  output logic stall_if_o
);
  logic [IF_STATE_LEN-1:0] state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_next;
  logic [INST_W-1:0] hold_inst;
  logic discard;
  assign tgt = jump_addr_i & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign pc_next = pc + ADDR_W'(4);
  assign stall_if_o = (state == IF_BUSY) && !mem.mem_valid_i;
  // fetch FSM: issue request, accept or park the returned word, redirect on jump
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_IDLE;
      pc <= RESET_PC;
      discard <= 1'b0;
      hold_inst <= '0;
      mem.mem_req_o <= 1'b0;
      mem.mem_addr_o <= '0;
      pc_o <= '0;
      inst_o <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      case (state)
        IF_IDLE: begin
          if (jump_i) pc <= tgt;
          else begin
            mem.mem_req_o <= 1'b1;
            mem.mem_addr_o <= pc;
            state <= IF_BUSY;
          end
        end
        IF_BUSY: begin
          if (!mem.mem_valid_i) begin
            if (jump_i) begin
              pc <= tgt;
              discard <= 1'b1;
            end
          end else begin
            mem.mem_req_o <= 1'b0;
            discard <= 1'b0;
            state <= (discard || jump_i || !stall_i) ? IF_IDLE : IF_HOLD;
            if (jump_i) pc <= tgt;
            else if (!discard) begin
              if (stall_i) hold_inst <= mem.mem_data_i;
              else begin
                inst_o <= mem.mem_data_i;
                pc_o <= pc;
                inst_valid_o <= 1'b1;
                pc <= pc_next;
              end
            end
          end
        end
        IF_HOLD: begin
          if (jump_i) begin
            pc <= tgt;
            state <= IF_IDLE;
          end else if (!stall_i) begin
            inst_o <= hold_inst;
            pc_o <= pc;
            inst_valid_o <= 1'b1;
            pc <= pc_next;
            state <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus randomized run against a stream-level fetch model
module tb_if_fetch;
  logic clk = 0, rst = 1, stall = 0, jump = 0;
  logic [31:0] jaddr = 0;
  logic mem_en = 0, m_valid = 0, t_valid = 0, t2_valid = 0;
  logic [31:0] m_data = 0, t_data = 0, t2_data = 0;
  logic [31:0] pc1, inst1, pc2, inst2;
  logic iv1, sif1, iv2, sif2;
  int n_tests = 0, n_fail = 0;
  if_fetch_if bus ();
  if_fetch_if bus2 ();
  assign bus.mem_valid_i = mem_en ? m_valid : t_valid;
  assign bus.mem_data_i = mem_en ? m_data : t_data;
  assign bus2.mem_valid_i = t2_valid;
  assign bus2.mem_data_i = t2_data;
  if_fetch dut (.clk(clk), .rst(rst), .stall_i(stall), .jump_i(jump), .jump_addr_i(jaddr), .mem(bus),
    .pc_o(pc1), .inst_o(inst1), .inst_valid_o(iv1), .stall_if_o(sif1));
  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst), .stall_i(stall), .jump_i(jump),
    .jump_addr_i(jaddr), .mem(bus2), .pc_o(pc2), .inst_o(inst2), .inst_valid_o(iv2), .stall_if_o(sif2));
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  int lat = 0, cnt = 0;
  bit resp = 0;
  always @(negedge clk) begin
    m_valid = 0;
    if (!bus.mem_req_o) begin
      cnt = 0;
      resp = 0;
      lat = $urandom_range(0, 3);
    end else if (!resp) begin
      if (cnt >= lat) begin
        m_valid = 1;
        m_data = word(bus.mem_addr_o);
        resp = 1;
      end else cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] d);
    t_valid = 1;
    t_data = d;
    tick;
    t_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    n_tests++;
    if ({bus.mem_req_o, bus.mem_addr_o, pc1, inst1, iv1, sif1} !== 99'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got req=%0b addr=%h pc=%h inst=%h v=%0b sif=%0b exp all zero",
        bus.mem_req_o, bus.mem_addr_o, pc1, inst1, iv1, sif1);
    end
  endtask

  task automatic test_basic;
    rst = 0;
    tick;
    n_tests++;
    if ({bus.mem_req_o, bus.mem_addr_o, sif1} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_req got req=%0b addr=%h sif=%0b exp 1 0 1", bus.mem_req_o, bus.mem_addr_o, sif1);
    end
    respond(32'h0050_0093);
    n_tests++;
    if ({iv1, inst1, pc1, bus.mem_req_o} !== {1'b1, 32'h0050_0093, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_deliver got v=%0b inst=%h pc=%h req=%0b exp 1 00500093 0 0", iv1, inst1, pc1, bus.mem_req_o);
    end
    tick;
    n_tests++;
    if ({iv1, bus.mem_req_o, bus.mem_addr_o} !== {1'b0, 1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL basic_next got v=%0b req=%0b addr=%h exp 0 1 4", iv1, bus.mem_req_o, bus.mem_addr_o);
    end
  endtask

  task automatic test_stall;
    respond(32'h1111_1111);
    tick;
    stall = 1;
    respond(32'h00A0_0113);
    n_tests++;
    if ({iv1, bus.mem_req_o, sif1} !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_hold got v=%0b req=%0b sif=%0b exp 000", iv1, bus.mem_req_o, sif1);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      n_tests++;
      if ({iv1, bus.mem_req_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_wait got v=%0b req=%0b exp 00", iv1, bus.mem_req_o);
      end
    end
    stall = 0;
    tick;
    n_tests++;
    if ({iv1, inst1, pc1} !== {1'b1, 32'h00A0_0113, 32'h8}) begin
      n_fail++;
      $display("FAIL stall_release got v=%0b inst=%h pc=%h exp 1 00a00113 8", iv1, inst1, pc1);
    end
    tick;
    n_tests++;
    if ({iv1, bus.mem_req_o, bus.mem_addr_o} !== {1'b0, 1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL stall_next got v=%0b req=%0b addr=%h exp 0 1 c", iv1, bus.mem_req_o, bus.mem_addr_o);
    end
  endtask

  task automatic test_jump_busy;
    jump = 1;
    jaddr = 32'h103;
    tick;
    jump = 0;
    n_tests++;
    if ({bus.mem_req_o, bus.mem_addr_o, sif1} !== {1'b1, 32'hC, 1'b1}) begin
      n_fail++;
      $display("FAIL jbusy_held got req=%0b addr=%h sif=%0b exp 1 c 1", bus.mem_req_o, bus.mem_addr_o, sif1);
    end
    tick;
    respond(32'hDEAD_BEEF);
    n_tests++;
    if ({iv1, bus.mem_req_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL jbusy_drop got v=%0b req=%0b exp 00", iv1, bus.mem_req_o);
    end
    tick;
    n_tests++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL jbusy_target got req=%0b addr=%h exp 1 100", bus.mem_req_o, bus.mem_addr_o);
    end
  endtask

  task automatic test_jump_valid;
    jump = 1;
    jaddr = 32'h200;
    respond(32'h1234_5678);
    jump = 0;
    n_tests++;
    if ({iv1, bus.mem_req_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL jvalid_drop got v=%0b req=%0b exp 00", iv1, bus.mem_req_o);
    end
    tick;
    n_tests++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL jvalid_target got req=%0b addr=%h exp 1 200", bus.mem_req_o, bus.mem_addr_o);
    end
  endtask

  task automatic test_jump_hold;
    stall = 1;
    respond(32'h0000_0055);
    jump = 1;
    jaddr = 32'h302;
    tick;
    jump = 0;
    n_tests++;
    if ({iv1, bus.mem_req_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL jhold_drop got v=%0b req=%0b exp 00", iv1, bus.mem_req_o);
    end
    stall = 0;
    tick;
    n_tests++;
    if ({iv1, bus.mem_req_o, bus.mem_addr_o} !== {1'b0, 1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL jhold_target got v=%0b req=%0b addr=%h exp 0 1 300", iv1, bus.mem_req_o, bus.mem_addr_o);
    end
  endtask

  task automatic test_reset_mid;
    rst = 1;
    tick;
    n_tests++;
    if ({bus.mem_req_o, bus.mem_addr_o, pc1, inst1, iv1, sif1} !== 99'h0) begin
      n_fail++;
      $display("FAIL rmid_outputs got req=%0b addr=%h pc=%h inst=%h v=%0b sif=%0b exp all zero",
        bus.mem_req_o, bus.mem_addr_o, pc1, inst1, iv1, sif1);
    end
    respond(32'hBAD0_BAD0);
    n_tests++;
    if ({iv1, bus.mem_req_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_stray got v=%0b req=%0b exp 00", iv1, bus.mem_req_o);
    end
    rst = 0;
    respond(32'hBAD1_BAD1);
    n_tests++;
    if ({iv1, bus.mem_req_o, bus.mem_addr_o} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL rmid_restart got v=%0b req=%0b addr=%h exp 0 1 0", iv1, bus.mem_req_o, bus.mem_addr_o);
    end
    respond(32'h0000_0013);
    n_tests++;
    if ({iv1, inst1, pc1} !== {1'b1, 32'h13, 32'h0}) begin
      n_fail++;
      $display("FAIL rmid_deliver got v=%0b inst=%h pc=%h exp 1 13 0", iv1, inst1, pc1);
    end
  endtask

  task automatic test_wrap;
    rst = 1;
    tick;
    rst = 0;
    tick;
    n_tests++;
    if ({bus2.mem_req_o, bus2.mem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_req got req=%0b addr=%h exp 1 fffffffc", bus2.mem_req_o, bus2.mem_addr_o);
    end
    t2_valid = 1;
    t2_data = 32'hCAFE_F00D;
    tick;
    t2_valid = 0;
    n_tests++;
    if ({iv2, inst2, pc2} !== {1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_deliver got v=%0b inst=%h pc=%h exp 1 cafef00d fffffffc", iv2, inst2, pc2);
    end
    tick;
    n_tests++;
    if ({bus2.mem_req_o, bus2.mem_addr_o} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_next got req=%0b addr=%h exp 1 0", bus2.mem_req_o, bus2.mem_addr_o);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, t, prev_addr;
    logic s, j, prev_req;
    int ndel;
    rst = 1;
    stall = 0;
    jump = 0;
    mem_en = 1;
    tick;
    tick;
    rst = 0;
    exp_pc = 0;
    prev_req = 0;
    prev_addr = 0;
    ndel = 0;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      jump = ($urandom_range(0, 99) < 4);
      jaddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      s = stall;
      j = jump;
      t = jaddr & ~32'h3;
      tick;
      if (iv1) begin
        n_tests++;
        if (s || j) begin
          n_fail++;
          $display("FAIL rnd_illegal_delivery got v=1 stall=%0b jump=%0b exp v=0", s, j);
        end
        n_tests++;
        if (pc1 !== exp_pc || inst1 !== word(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_deliver got pc=%h inst=%h exp pc=%h inst=%h", pc1, inst1, exp_pc, word(exp_pc));
        end
        exp_pc = exp_pc + 4;
        ndel++;
      end else if (j) exp_pc = t;
      if (bus.mem_req_o && !prev_req) begin
        n_tests++;
        if (bus.mem_addr_o !== exp_pc) begin
          n_fail++;
          $display("FAIL rnd_fetch_addr got %h exp %h", bus.mem_addr_o, exp_pc);
        end
      end
      if (bus.mem_req_o && prev_req) begin
        n_tests++;
        if (bus.mem_addr_o !== prev_addr) begin
          n_fail++;
          $display("FAIL rnd_addr_stable got %h exp %h", bus.mem_addr_o, prev_addr);
        end
      end
      n_tests++;
      if (sif1 !== (bus.mem_req_o && !bus.mem_valid_i)) begin
        n_fail++;
        $display("FAIL rnd_stall_if got %0b exp %0b", sif1, bus.mem_req_o && !bus.mem_valid_i);
      end
      prev_req = bus.mem_req_o;
      prev_addr = bus.mem_addr_o;
    end
    n_tests++;
    if (ndel < 100) begin
      n_fail++;
      $display("FAIL rnd_progress got %0d deliveries exp >= 100", ndel);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_jump_busy;
    test_jump_valid;
    test_jump_hold;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
